// File: rtl/calc_mvd_cost_nc.sv
// calc_mvd_cost_nc: picks the cheapest of NUM_CAND MV predictors and returns its lambda-weighted MVD cost.
// Define CALC_MVD_COST_SAT_EN to saturate mvd_cost_int64 on overflow instead of wrapping.
module calc_mvd_cost_nc #(
    parameter int NUM_CAND    = 2,
    parameter int MV_W        = 16,
    parameter int LAMBDA_FRAC = 32
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic                       ap_start,
    input  logic                       ap_ce,
    output logic                       ap_ready,
    output logic                       ap_idle,
    output logic                       ap_done,
    input  logic [31:0]                x,
    input  logic [31:0]                y,
    input  logic [31:0]                mv_shift,
    input  logic [NUM_CAND*2*MV_W-1:0] mv_cand,
    input  logic [63:0]                lambda_sqrt_integer_int64,
    input  logic [63:0]                lambda_sqrt_decimal_int64,
    output logic [63:0]                bitcost,
    output logic                       bitcost_ap_vld,
    output logic [2:0]                 best_idx,
    output logic [63:0]                mvd_cost_int64,
    output logic                       mvd_cost_int64_ap_vld
);
    typedef enum logic [2:0] {IDLE, EVAL, MUL1, MUL2, DONE} state_t;
    state_t state, state_nx;
    logic [2:0]                 idx, best_i;
    logic [31:0]                sx, sy;
    logic [NUM_CAND*2*MV_W-1:0] cand;
    logic [63:0]                lam_int, lam_dec;
    logic [7:0]                 best_cost, cur_cost, idx_cost;
    logic [MV_W-1:0]            cx, cy;
    logic [32:0]                dx, dy;
    logic [63:0]                p_int, p_dec, mvd, p_int_nx, p_dec_nx, mvd_nx;
    logic                       ovf, ovf_nx;
    logic                       unused;

    // a=0 -> 1, a=1 -> 3, otherwise 3 + 2*floor(log2(a))
    function automatic logic [6:0] comp_cost(input logic [32:0] d);
        logic [32:0] a;
        logic [6:0]  c;
        a = d[32] ? -d : d;
        c = (a == 33'd0) ? 7'd1 : 7'd3;
        for (int i = 1; i < 33; i++)
            if (a[i]) c = 7'(3 + 2 * i);
        return c;
    endfunction

    assign unused   = ^mv_shift[31:5];
    assign cx       = cand[int'(idx) * 2 * MV_W +: MV_W];
    assign cy       = cand[(int'(idx) * 2 + 1) * MV_W +: MV_W];
    assign dx       = {sx[31], sx} - {{(33 - MV_W){cx[MV_W-1]}}, cx};
    assign dy       = {sy[31], sy} - {{(33 - MV_W){cy[MV_W-1]}}, cy};
    assign idx_cost = (int'(idx) + 1 < NUM_CAND - 1) ? 8'(idx) + 8'd1 : 8'(NUM_CAND - 1);
    assign cur_cost = 8'(comp_cost(dx)) + 8'(comp_cost(dy)) + idx_cost;

`ifdef CALC_MVD_COST_SAT_EN
    logic [127:0] prod_int, prod_dec;
    logic [64:0]  sum;
    assign prod_int = {64'd0, lam_int} * {120'd0, best_cost};
    assign prod_dec = {64'd0, lam_dec} * {120'd0, best_cost};
    assign p_int_nx = prod_int[63:0];
    assign p_dec_nx = 64'(prod_dec >> LAMBDA_FRAC);
    assign ovf_nx   = |prod_int[127:64];
    assign sum      = {1'b0, p_int} + {1'b0, p_dec};
    assign mvd_nx   = (ovf || sum[64]) ? '1 : sum[63:0];
`else
    logic [71:0] prod_dec;
    assign prod_dec = {8'd0, lam_dec} * {64'd0, best_cost};
    assign p_int_nx = lam_int * {56'd0, best_cost};
    assign p_dec_nx = 64'(prod_dec >> LAMBDA_FRAC);
    assign ovf_nx   = 1'b0;
    assign mvd_nx   = ovf ? '1 : p_int + p_dec;
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else if (ap_ce) state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = ap_start ? EVAL : IDLE;
            EVAL:    state_nx = (idx == 3'(NUM_CAND - 1)) ? MUL1 : EVAL;
            MUL1:    state_nx = MUL2;
            MUL2:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ap_idle               = (state == IDLE);
        bitcost_ap_vld        = ap_done;
        mvd_cost_int64_ap_vld = ap_done;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ap_ready       <= 1'b0;
            ap_done        <= 1'b0;
            idx            <= '0;
            best_i         <= '0;
            best_cost      <= '0;
            sx             <= '0;
            sy             <= '0;
            cand           <= '0;
            lam_int        <= '0;
            lam_dec        <= '0;
            p_int          <= '0;
            p_dec          <= '0;
            ovf            <= 1'b0;
            mvd            <= '0;
            bitcost        <= '0;
            best_idx       <= '0;
            mvd_cost_int64 <= '0;
        end else if (ap_ce) begin
            ap_ready <= (state == IDLE) && ap_start;
            ap_done  <= (state == DONE);
            case (state)
                IDLE: if (ap_start) begin
                    sx      <= x << mv_shift[4:0];
                    sy      <= y << mv_shift[4:0];
                    cand    <= mv_cand;
                    lam_int <= lambda_sqrt_integer_int64;
                    lam_dec <= lambda_sqrt_decimal_int64;
                    idx     <= '0;
                end
                EVAL: begin
                    idx <= idx + 3'd1;
                    if (idx == 3'd0 || cur_cost < best_cost) begin
                        best_cost <= cur_cost;
                        best_i    <= idx;
                    end
                end
                MUL1: begin
                    p_int <= p_int_nx;
                    p_dec <= p_dec_nx;
                    ovf   <= ovf_nx;
                end
                MUL2: mvd <= mvd_nx;
                default: begin
                    bitcost        <= 64'(best_cost);
                    best_idx       <= best_i;
                    mvd_cost_int64 <= mvd;
                end
            endcase
        end
    end
endmodule
